// File: rtl/mem_pkg.sv
// Shared definitions for the memory-bus arbiter: widths, device ids and FSM states.
package mem_pkg;

  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned DEV_COUNT = 7;

  localparam logic [2:0] DRAM  = 3'd0;
  localparam logic [2:0] DROM  = 3'd1;
  localparam logic [2:0] DMAT  = 3'd2;
  localparam logic [2:0] DINT  = 3'd3;
  localparam logic [2:0] DREG  = 3'd4;
  localparam logic [2:0] DEXEC = 3'd5;
  localparam logic [2:0] DSPI  = 3'd6;
  localparam logic [2:0] DNONE = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

endpackage

// File: rtl/mem_arbiter_decode.sv
// Address decoder: maps addr[15:12] to a device id while an access is active.
import mem_pkg::*;

module mem_arbiter_decode (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              rd_i,
  input  logic              wr_i,
  output logic              hit_o,
  output logic [2:0]        did_o
);

  // Only the page nibble selects a device; the offset passes through to the bus.
  logic unused_offset;
  assign unused_offset = ^addr_i[11:0];

  always_comb begin
    did_o = DNONE;
    hit_o = 1'b0;
    if (rd_i || wr_i) begin
      case (addr_i[15:12])
        4'h0:    did_o = DRAM;
        4'h1:    did_o = DROM;
        4'h2:    did_o = DMAT;
        4'h3:    did_o = DINT;
        4'h4:    did_o = DREG;
        4'h5:    did_o = DEXEC;
        4'h6:    did_o = DSPI;
        default: did_o = DNONE;
      endcase
      hit_o = (did_o != DNONE);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master round-robin bus arbiter and transaction sequencer with bounded device wait.
import mem_pkg::*;

module mem_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [1:0]             m_req_i,
  input  logic [1:0]             m_wr_i,
  input  logic [1:0][ADDR_W-1:0] m_addr_i,
  input  logic [1:0][DATA_W-1:0] m_wdata_i,
  output logic [1:0]             m_gnt_o,
  output logic [1:0]             m_done_o,
  output logic                   m_err_o,
  output logic [DATA_W-1:0]      m_rdata_o,
  output logic                   bus_rd_o,
  output logic                   bus_wr_o,
  output logic [ADDR_W-1:0]      bus_addr_o,
  output logic [DATA_W-1:0]      bus_wdata_o,
  output logic [2:0]             dev_sel_o,
  input  logic [DEV_COUNT-1:0]   dev_ready_i,
  input  logic [DATA_W-1:0]      dev_rdata_i
);

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic                wr_q, wr_d;
  logic                rr_q, rr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [1:0]          done_q, done_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                in_access;
  logic                hit;
  logic [2:0]          did;
  logic                legal;
  logic                ready;
  logic                winner;
  logic [DEV_COUNT:0]  ready_x;

  assign in_access = (state_q == ACCESS);

  mem_arbiter_decode u_decode (
    .addr_i (addr_q),
    .rd_i   (in_access & ~wr_q),
    .wr_i   (in_access & wr_q),
    .hit_o  (hit),
    .did_o  (did)
  );

  // ROM is read-only; a write there is rejected without touching the bus.
  assign legal   = hit & ~(wr_q & (did == DROM));
  assign ready_x = {1'b0, dev_ready_i};
  assign ready   = legal & ready_x[did];
  assign winner  = (&m_req_i) ? rr_q : m_req_i[1];

  // Strobes and device select are decoded from registered state only.
  assign bus_rd_o    = legal & ~wr_q;
  assign bus_wr_o    = legal & wr_q;
  assign dev_sel_o   = did;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;
  assign m_done_o    = done_q;
  assign m_err_o     = err_q;
  assign m_rdata_o   = rdata_q;

  // Grant is issued in the same IDLE cycle that sees the request.
  always_comb begin
    m_gnt_o = '0;
    if ((state_q == IDLE) && (|m_req_i) && !rst_i) m_gnt_o[winner] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    wr_d    = wr_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = '0;
    err_d   = 1'b0;
    rdata_d = '0;
    case (state_q)
      IDLE: begin
        if (|m_req_i) begin
          owner_d = winner;
          wr_d    = m_wr_i[winner];
          addr_d  = m_addr_i[winner];
          wdata_d = m_wdata_i[winner];
          cnt_d   = '0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!legal) begin
          state_d         = RESP;
          done_d[owner_q] = 1'b1;
          err_d           = 1'b1;
        end else if (ready) begin
          state_d         = RESP;
          done_d[owner_q] = 1'b1;
          rdata_d         = wr_q ? '0 : dev_rdata_i;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d         = RESP;
          done_d[owner_q] = 1'b1;
          err_d           = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        rr_d    = ~owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      wr_q    <= 1'b0;
      rr_q    <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      wr_q    <= wr_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

endmodule
